// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: hazard / forwarding unit for a 5-stage F/D/E/M/W pipeline.
//
// What it does:
//   - Forwards operands into E from M (highest priority) or from W.
//   - Stalls F/D and bubbles E on a load-use hazard or on a multi-cycle hazard.
//   - Freezes the whole pipeline while a load in M waits for data memory.
//   - Flushes D/E on a taken branch.
//   - Tracks one outstanding MUL/DIV op with an IDLE/BUSY scoreboard.
//
// Optional build macro:
//   HZ_PERF_CNT_EN - adds saturating perf counters stall_cnt, flush_cnt, mc_cnt.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   rs_d, mc_d                   D-stage source addresses / multi-cycle flag
//   rs_e, rd_e, regwrite_e,      E-stage sources, destination, write enable,
//   memread_e, mc_start_e,       load flag, multi-cycle issue,
//   branch_taken_e               taken branch
//   rd_m, regwrite_m, memread_m  M-stage destination, write enable, load flag
//   rd_w, regwrite_w             W-stage destination, write enable
//   mem_ready, mc_done           data memory done / multi-cycle result written
//   fwd_e                        per operand: 00 regfile, 10 from M, 01 from W
//   stall_f/d/e/m                hold stage register
//   flush_d/e                    bubble stage register on the next edge
//   mc_busy                      multi-cycle op outstanding
//   stall_cnt, flush_cnt, mc_cnt perf counters (HZ_PERF_CNT_EN only)
module hazard_unit_sb #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] rs_d,
    input  logic                      mc_d,
    input  logic [NUM_SRC*REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0]         rd_e,
    input  logic                      regwrite_e,
    input  logic                      memread_e,
    input  logic                      mc_start_e,
    input  logic                      branch_taken_e,
    input  logic [REG_AW-1:0]         rd_m,
    input  logic [REG_AW-1:0]         rd_w,
    input  logic                      regwrite_m,
    input  logic                      regwrite_w,
    input  logic                      memread_m,
    input  logic                      mem_ready,
    input  logic                      mc_done,
    output logic [NUM_SRC*2-1:0]      fwd_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      mc_busy
`ifdef HZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt,
    output logic [CNT_W-1:0]          mc_cnt
`endif
);

    if (NUM_SRC < 1 || NUM_SRC > 3 || CNT_W < 1) begin : g_bad_param
        $error("hazard_unit_sb: unsupported NUM_SRC or CNT_W");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [REG_AW-1:0] mc_rd;
    logic              mem_wait;
    logic              lu_hit;
    logic              dep_hit;
    logic              lu;
    logic              dep;
    logic              struct_hz;
    logic              mc_go;

    assign mc_busy  = (state == BUSY);
    assign mem_wait = memread_m & ~mem_ready;

    // D-stage source matches against the E destination and the pending
    // multi-cycle destination. Register 0 never creates a dependency.
    always_comb begin
        lu_hit  = 1'b0;
        dep_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rd_e != '0 && rs_d[i*REG_AW +: REG_AW] == rd_e)
                lu_hit = 1'b1;
            if (mc_rd != '0 && rs_d[i*REG_AW +: REG_AW] == mc_rd)
                dep_hit = 1'b1;
        end
    end

    assign lu        = regwrite_e & (memread_e | mc_start_e) & lu_hit;
    assign dep       = mc_busy & dep_hit;
    assign struct_hz = mc_busy & mc_d;

    // Forwarding into E. M is checked first, so it wins when M and W
    // both write the same register.
    always_comb begin
        fwd_e = '0;
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (regwrite_m && rd_m != '0 && rd_m == rs_e[i*REG_AW +: REG_AW])
                    fwd_e[i*2 +: 2] = 2'b10;
                else if (regwrite_w && rd_w != '0 && rd_w == rs_e[i*REG_AW +: REG_AW])
                    fwd_e[i*2 +: 2] = 2'b01;
            end
        end
    end

    // Pipeline control, in priority order:
    //   1. memory wait freezes every stage and suppresses all flushes;
    //   2. a taken branch discards D, so D-stage hazards are irrelevant;
    //   3. a D-stage hazard holds F/D and bubbles E.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!reset) begin
            if (mem_wait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end else if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu | dep | struct_hz) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // A multi-cycle op is accepted when it leaves E while the FSM is idle
    // and the pipeline is not frozen.
    assign mc_go = (state == IDLE) & mc_start_e & ~stall_e & ~mem_wait;

    // Multi-cycle scoreboard. The FSM holds while the pipeline is frozen.
    // A start seen while BUSY and a done seen while IDLE are both ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mc_rd <= '0;
        end else if (!mem_wait) begin
            case (state)
                IDLE: if (mc_go) begin
                    state <= BUSY;
                    mc_rd <= rd_e;
                end
                BUSY: if (mc_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HZ_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            mc_cnt    <= '0;
        end else begin
            if (stall_d && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_d && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            if (mc_go   && mc_cnt    != '1) mc_cnt    <= mc_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench for hazard_unit_sb (REG_AW=5, NUM_SRC=2, CNT_W=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge. Each scenario pushes its expected output word into a queue when it
// drives a cycle and pops and compares that word at the sample point.
module tb_hazard_unit_sb;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;
    localparam int OW      = NUM_SRC*2 + 7;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_SRC*REG_AW-1:0] rs_d, rs_e;
    logic                      mc_d, regwrite_e, memread_e, mc_start_e, branch_taken_e;
    logic [REG_AW-1:0]         rd_e, rd_m, rd_w;
    logic                      regwrite_m, regwrite_w, memread_m, mem_ready, mc_done;
    logic [NUM_SRC*2-1:0]      fwd_e;
    logic                      stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mc_busy;
`ifdef HZ_PERF_CNT_EN
    logic [CNT_W-1:0]          stall_cnt, flush_cnt, mc_cnt;
    logic [3*CNT_W-1:0]        cnt_q[$];
`endif

    logic [OW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    hazard_unit_sb #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .mc_d(mc_d), .rs_e(rs_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .memread_e(memread_e), .mc_start_e(mc_start_e),
        .branch_taken_e(branch_taken_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memread_m(memread_m),
        .mem_ready(mem_ready), .mc_done(mc_done), .fwd_e(fwd_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .mc_busy(mc_busy)
`ifdef HZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mc_cnt(mc_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [OW-1:0] mk(input logic [NUM_SRC*2-1:0] f, input logic sf, sd,
                                         se, sm, fd, fe, b);
        return {f, sf, sd, se, sm, fd, fe, b};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {fwd_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mc_busy};
    endfunction

    task automatic defaults();
        reset = 1'b0; rs_d = '0; mc_d = 1'b0; rs_e = '0; rd_e = '0;
        regwrite_e = 1'b0; memread_e = 1'b0; mc_start_e = 1'b0; branch_taken_e = 1'b0;
        rd_m = '0; rd_w = '0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        memread_m = 1'b0; mem_ready = 1'b1; mc_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] got, want;
        defaults();
        reset = 1'b1; memread_m = 1'b1; mem_ready = 1'b0; regwrite_m = 1'b1;
        rd_m = 5'd5; rs_e = {5'd5, 5'd5}; branch_taken_e = 1'b1;
        tick();
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset[%0d] got=%b exp=%b", s, got, want);
            end
            tick();
        end
    endtask

    task automatic test_forward();
        logic [OW-1:0] got, want;
        logic         t_wm [6] = '{1, 0, 1, 1, 0, 1};
        logic [4:0]   t_rm [6] = '{5, 5, 0, 6, 6, 6};
        logic         t_ww [6] = '{1, 1, 1, 1, 0, 1};
        logic [4:0]   t_rw [6] = '{5, 5, 0, 4, 6, 6};
        logic [4:0]   t_s1 [6] = '{3, 3, 0, 6, 6, 6};
        logic [4:0]   t_s0 [6] = '{5, 5, 0, 4, 6, 6};
        logic [3:0]   t_f  [6] = '{4'b0010, 4'b0001, 4'b0000, 4'b1001, 4'b0000, 4'b1010};
        for (int s = 0; s < 6; s++) begin
            defaults();
            regwrite_m = t_wm[s]; rd_m = t_rm[s]; regwrite_w = t_ww[s]; rd_w = t_rw[s];
            rs_e = {t_s1[s], t_s0[s]};
            exp_q.push_back(mk(t_f[s], 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL forward[%0d] got=%b exp=%b", s, got, want);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        logic [OW-1:0] got, want;
        for (int s = 0; s < 5; s++) begin
            defaults();
            case (s)
                0: begin  // load x7 in E, D reads x7 as operand 1
                    regwrite_e = 1; memread_e = 1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
                    exp_q.push_back(mk(4'b0000, 1, 1, 0, 0, 0, 1, 0));
                end
                1: begin  // load moved to M, bubble in E, D held
                    memread_m = 1; regwrite_m = 1; rd_m = 5'd7; rs_d = {5'd7, 5'd0};
                    exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
                end
                2: begin  // consumer in E, load data from W
                    rs_e = {5'd7, 5'd0}; regwrite_w = 1; rd_w = 5'd7;
                    exp_q.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 0, 0));
                end
                3: begin  // load to x0 never stalls
                    regwrite_e = 1; memread_e = 1; rd_e = 5'd0; rs_d = '0;
                    exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
                end
                default: begin  // load without register write
                    memread_e = 1; rd_e = 5'd7; rs_d = {5'd0, 5'd7};
                    exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
                end
            endcase
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL load_use[%0d] got=%b exp=%b", s, got, want);
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        logic [OW-1:0] got, want;
        for (int s = 0; s < 5; s++) begin
            defaults();
            branch_taken_e = 1;
            if (s < 4) begin
                memread_m = 1; regwrite_e = 1; memread_e = 1; rd_e = 5'd4; rs_d = {5'd0, 5'd4};
            end
            mem_ready = (s >= 3) ? 1'b1 : 1'b0;
            if (s == 4) mem_ready = 1'b0;  // no load in M: not-ready is irrelevant
            if (s < 3) exp_q.push_back(mk(4'b0000, 1, 1, 1, 1, 0, 0, 0));
            else       exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 0));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mem_wait[%0d] got=%b exp=%b", s, got, want);
            end
            tick();
        end
    endtask

    task automatic test_mc_busy();
        logic [OW-1:0] got, want;
        for (int s = 0; s < 19; s++) begin
            defaults();
            if (s == 0) begin
                mc_start_e = 1; regwrite_e = 1; rd_e = 5'd9; rs_d = {5'd0, 5'd9};
                exp_q.push_back(mk(4'b0000, 1, 1, 0, 0, 0, 1, 0));
            end else if (s <= 10) begin
                rs_d = {5'd0, 5'd9};
                mc_done = (s == 10);
                exp_q.push_back(mk(4'b0000, 1, 1, 0, 0, 0, 1, 1));
            end else if (s == 11) begin
                rs_d = {5'd0, 5'd9};
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            end else if (s == 12) begin  // done while idle
                mc_done = 1;
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            end else if (s == 13) begin
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            end else if (s == 14) begin  // start during memory wait: FSM frozen
                mc_start_e = 1; regwrite_e = 1; memread_m = 1; mem_ready = 0;
                exp_q.push_back(mk(4'b0000, 1, 1, 1, 1, 0, 0, 0));
            end else if (s == 15) begin
                mc_start_e = 1; regwrite_e = 1;
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            end else if (s == 16) begin  // busy with x0 destination: no dep stall
                rs_d = '0;
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1));
            end else if (s == 17) begin  // structural
                mc_d = 1;
                exp_q.push_back(mk(4'b0000, 1, 1, 0, 0, 0, 1, 1));
            end else begin  // branch beats structural
                mc_d = 1; branch_taken_e = 1;
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 1));
            end
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mc_busy[%0d] got=%b exp=%b", s, got, want);
            end
            tick();
        end
    endtask

    // Entered with the FSM BUSY (left so by test_mc_busy).
    task automatic test_reset_mid_op();
        logic [OW-1:0] got, want;
        for (int s = 0; s < 4; s++) begin
            defaults();
            mc_d = 1;
            reset = (s < 2);
            if (s == 2) begin mc_done = 1; rs_d = {5'd0, 5'd9}; end
            if (s == 0) exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1));
            else        exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_op[%0d] got=%b exp=%b", s, got, want);
            end
            tick();
        end
    endtask

`ifdef HZ_PERF_CNT_EN
    task automatic test_perf();
        logic [OW-1:0]      got, want;
        logic [3*CNT_W-1:0] cgot, cwant;
        for (int s = 0; s < 25; s++) begin
            defaults();
            if (s == 0) begin
                reset = 1;
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            end else if (s <= 20) begin
                regwrite_e = 1; memread_e = 1; rd_e = 5'd7; rs_d = {5'd0, 5'd7};
                exp_q.push_back(mk(4'b0000, 1, 1, 0, 0, 0, 1, 0));
            end else if (s == 21) begin
                mc_start_e = 1;
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            end else if (s == 22) begin
                mc_done = 1;
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 1));
            end else if (s == 23) begin
                branch_taken_e = 1;
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 0));
            end else begin
                exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
            end
            if (s == 5)  cnt_q.push_back({4'd4, 4'd0, 4'd0});
            if (s == 24) cnt_q.push_back({4'd15, 4'd1, 4'd1});
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL perf[%0d] got=%b exp=%b", s, got, want);
            end
            if (s == 5 || s == 24) begin
                cgot = {stall_cnt, flush_cnt, mc_cnt}; cwant = cnt_q.pop_front(); checks++;
                if (cgot !== cwant) begin
                    failures++;
                    $display("FAIL perf_cnt[%0d] got=%h exp=%h", s, cgot, cwant);
                end
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_mc_busy();
        test_reset_mid_op();
`ifdef HZ_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Parametrised hazard/forwarding unit for the 5-stage pipeline (F/D/E/M/W).
- Forwards operands into E from M and W for NUM_SRC source operands.
- Detects load-use and multi-cycle-unit dependencies and inserts bubbles.
- Freezes the pipeline while data memory is not ready and flushes D/E on a taken branch. Tracks one outstanding multi-cycle (MUL/DIV) op with a busy/scoreboard FSM.

Parameters:
- REG_AW, 5, register address width; address 0 is the hard-wired zero register.
- NUM_SRC, 2, source operands per instruction (1..3).
- CNT_W, 16, perf counter width (only used with HZ_PERF_CNT_EN).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- rs_d  in  NUM_SRC*REG_AW  D-stage source addresses, operand i at [i*REG_AW +: REG_AW]
- mc_d  in  1  D-stage instruction is a multi-cycle op
- rs_e  in  NUM_SRC*REG_AW  E-stage source addresses
- rd_e  in  REG_AW  E-stage destination
- regwrite_e  in  1  E-stage writes a register
- memread_e  in  1  E-stage is a load
- mc_start_e  in  1  E-stage issues a multi-cycle op (destination rd_e)
- branch_taken_e  in  1  branch/jump resolved taken in E
- rd_m, rd_w  in  REG_AW  M/W destinations
- regwrite_m, regwrite_w  in  1  M/W write enables
- memread_m  in  1  M-stage is a load
- mem_ready  in  1  data memory completes access this cycle
- mc_done  in  1  multi-cycle unit result written back this cycle
- fwd_e  out  NUM_SRC*2  per operand: 00 regfile, 10 from M, 01 from W
- stall_f, stall_d, stall_e, stall_m  out  1  hold stage register
- flush_d, flush_e  out  1  insert bubble into stage register next edge
- mc_busy  out  1  multi-cycle op outstanding

Behaviour:
- Reset: all outputs 0, FSM IDLE, mc_rd=0, counters 0. Reset mid-op discards the outstanding op; a later mc_done is ignored.
- Forwarding (combinational), per operand i:
  - 10 if regwrite_m & rd_m!=0 & rd_m==rs_e[i].
  - Else 01 if regwrite_w & rd_w!=0 & rd_w==rs_e[i].
  - Else 00. M has priority over W.
  - fwd_e=0 while reset is high.
- match_d(x): any rs_d[i]==x with x!=0.
- mem_wait = memread_m & ~mem_ready.
  - Forces stall_f, stall_d, stall_e, stall_m = 1.
  - Forces flush_d = flush_e = 0.
  - No FSM transition occurs.
  - Overrides all other conditions.
- lu = regwrite_e & (memread_e | mc_start_e) & match_d(rd_e).
- dep = mc_busy & match_d(mc_rd).
- struct = mc_busy & mc_d.
- Taken branch (branch_taken_e & ~mem_wait): flush_d=1, flush_e=1, no stalls. Branch beats lu/dep/struct because the D instruction is discarded.
- Else if lu | dep | struct: stall_f=1, stall_d=1, flush_e=1, stall_e=stall_m=0.
- Otherwise all controls 0.
- FSM IDLE→BUSY: on mc_start_e & ~stall_e; latch mc_rd=rd_e (rd_e=0 latches 0, so no dep stalls).
- FSM BUSY→IDLE: on mc_done; dep/struct released from the next cycle; same-cycle W forwarding covers the done cycle.
- mc_start_e in BUSY cannot occur (struct stall); if it does, it is ignored.
- mc_done in IDLE is ignored.
- mc_busy = (state==BUSY), registered.

Optional Feature:
- Macro HZ_PERF_CNT_EN.
- When defined, adds outputs stall_cnt, flush_cnt, mc_cnt (CNT_W each).
  - stall_cnt: +1 every cycle stall_d=1.
  - flush_cnt: +1 every cycle flush_d=1.
  - mc_cnt: +1 every IDLE→BUSY transition.
  - Counters saturate at all-ones and clear on reset.
- When undefined: ports absent, no counter logic.

Test Plan:
- regwrite_m=1, rd_m=5, regwrite_w=1, rd_w=5, rs_e[0]=5 -> fwd_e[1:0]=10; set regwrite_m=0 -> 01; set rd_m=rd_w=0 with rs_e[0]=0 -> 00.
- Load in E, rd_e=7, memread_e=1, rs_d[1]=7 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle, then 0 once the load moves to M.
- memread_m=1, mem_ready=0 for 3 cycles with branch_taken_e=1 -> all four stalls=1 and flush_d=flush_e=0 for 3 cycles; on mem_ready=1 -> flush_d=flush_e=1.
- mc_start_e, rd_e=9; next instruction rs_d[0]=9 held 10 cycles; mc_done pulsed in cycle 10 -> mc_busy=1 and stall_d=1 through cycle 10, both 0 in cycle 11.
- mc_busy=1, mc_d=1 -> struct stall; then reset asserted while BUSY -> mc_busy=0 next edge, a later mc_done causes no change.
- With HZ_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt=15 (saturated); without the macro the bench compiles with no counter ports.
